// File: rtl/csp_sampler_pkg.sv
// csp_sampler_pkg
//   Shared types and constants for the constraint-checker sample driver.
//   - state_e   : driver FSM states
//   - LFSR_POLY : Galois feedback mask of the 32-bit candidate LFSR
//   - LFSR_ONE  : substitute value for an all-zero seed (avoids lock-up)
//   - words_f   : number of 32-bit LFSR words needed to fill a candidate
package csp_sampler_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        CHECK = 2'd2,
        OUT   = 2'd3
    } state_e;

    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
    localparam logic [31:0] LFSR_ONE  = 32'h0000_0001;

    function automatic int unsigned words_f(input int unsigned cand_w);
        return (cand_w + 32'd31) / 32'd32;
    endfunction

endpackage

// File: rtl/csp_lfsr32.sv
// csp_lfsr32
//   32-bit Galois LFSR (right-shifting, feedback mask LFSR_POLY).
//   A zero seed, from either the load port or the reset value, is replaced
//   by LFSR_ONE so the register can never lock up at zero.
// Ports
//   clk      in   clock, rising edge
//   rst      in   async reset, active-high
//   load_i   in   load seed_i (has priority over step_i)
//   seed_i   in   32-bit seed
//   step_i   in   advance one step
//   state_o  out  current LFSR state
//   next_o   out  state after one step from state_o
module csp_lfsr32
    import csp_sampler_pkg::*;
#(
    parameter logic [31:0] SEED_RST = 32'hACE1_2024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic [31:0] seed_i,
    input  logic        step_i,
    output logic [31:0] state_o,
    output logic [31:0] next_o
);

    localparam logic [31:0] RST_VAL = (SEED_RST == 32'h0) ? LFSR_ONE : SEED_RST;

    logic [31:0] state_q;
    logic [31:0] state_d;
    logic [31:0] step_val;

    assign step_val = {1'b0, state_q[31:1]} ^ (state_q[0] ? LFSR_POLY : 32'h0);

    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = (seed_i == 32'h0) ? LFSR_ONE : seed_i;
        end else if (step_i) begin
            state_d = step_val;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RST_VAL;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;
    assign next_o  = step_val;

endmodule

// File: rtl/csp_sample_driver.sv
// csp_sample_driver
//   Candidate generator for the constraint checker. Fills a candidate from
//   the LFSR one 32-bit word per cycle, waits CHK_LAT+1 cycles for the
//   checker verdict, retries up to MAX_TRIES times and hands the result
//   downstream over valid/ready.
//   Optional build macro CSP_SAMPLER_STATS_EN adds saturating statistics
//   counters (stat_tries_o, stat_ok_o) with a synchronous clear (stat_clr).
// Ports
//   clk, rst          clock / async active-high reset
//   seed_wr, seed_i   LFSR seed load (IDLE only)
//   req_i             request one sample (IDLE only)
//   busy_o            FSM not idle
//   cand_o            candidate to checker;  sat_i  checker verdict
//   smp_valid_o/smp_ready_i          output handshake
//   smp_data_o/smp_fail_o/smp_tries_o  sample, budget-exhausted flag, tries used
//
// state | meaning
// IDLE  | waiting for req_i; seed writes accepted
// FILL  | shifting WORDS LFSR words into the candidate
// CHECK | candidate held for CHK_LAT+1 cycles, verdict taken in the last
// OUT   | result presented until smp_ready_i
module csp_sample_driver
    import csp_sampler_pkg::*;
#(
    parameter int          CAND_W    = 551,
    parameter int          CHK_LAT   = 0,
    parameter int          MAX_TRIES = 1024,
    parameter logic [31:0] SEED_RST  = 32'hACE1_2024
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               seed_wr,
    input  logic [31:0]                        seed_i,
    input  logic                               req_i,
    output logic                               busy_o,
    output logic [CAND_W-1:0]                  cand_o,
    input  logic                               sat_i,
    output logic                               smp_valid_o,
    input  logic                               smp_ready_i,
    output logic [CAND_W-1:0]                  smp_data_o,
    output logic                               smp_fail_o,
    output logic [$clog2(MAX_TRIES+1)-1:0]     smp_tries_o
`ifdef CSP_SAMPLER_STATS_EN
    ,
    input  logic                               stat_clr,
    output logic [31:0]                        stat_tries_o,
    output logic [31:0]                        stat_ok_o
`endif
);

    localparam int WORDS  = int'(words_f(CAND_W));
    localparam int SH_W   = WORDS * 32;
    localparam int TRY_W  = $clog2(MAX_TRIES + 1);
    localparam int FILL_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int CHK_W  = (CHK_LAT > 0) ? $clog2(CHK_LAT + 1) : 1;

    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(WORDS - 1);
    localparam logic [CHK_W-1:0]  CHK_LOAD  = CHK_W'(CHK_LAT);
    localparam logic [TRY_W-1:0]  TRY_MAX   = TRY_W'(MAX_TRIES);

    state_e              state_q;
    logic [SH_W-1:0]     shreg_q;
    logic [SH_W-1:0]     shreg_shift;
    logic [FILL_W-1:0]   fill_cnt_q;
    logic [CHK_W-1:0]    chk_cnt_q;
    logic [TRY_W-1:0]    tries_q;
    logic [CAND_W-1:0]   smp_data_q;
    logic                smp_fail_q;
    logic [TRY_W-1:0]    smp_tries_q;

    logic [31:0]         lfsr_next;
    logic [31:0]         lfsr_state_unused;

    csp_lfsr32 #(
        .SEED_RST (SEED_RST)
    ) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .load_i  ((state_q == IDLE) && seed_wr),
        .seed_i  (seed_i),
        .step_i  (state_q == FILL),
        .state_o (lfsr_state_unused),
        .next_o  (lfsr_next)
    );

    // The shift register is a whole number of words; the first word ends at
    // the LSBs and the top bits of the last word fall off the candidate.
    assign shreg_shift = SH_W'({lfsr_next, shreg_q} >> 32);

    generate
        if (SH_W > CAND_W) begin : g_excess
            logic excess_unused;
            assign excess_unused = ^shreg_q[SH_W-1:CAND_W];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            fill_cnt_q  <= '0;
            chk_cnt_q   <= '0;
            tries_q     <= '0;
            smp_data_q  <= '0;
            smp_fail_q  <= 1'b0;
            smp_tries_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_i) begin
                        state_q    <= FILL;
                        fill_cnt_q <= FILL_LAST;
                        tries_q    <= '0;
                    end
                end
                FILL: begin
                    shreg_q <= shreg_shift;
                    if (fill_cnt_q == '0) begin
                        state_q   <= CHECK;
                        chk_cnt_q <= CHK_LOAD;
                        tries_q   <= tries_q + TRY_W'(1);
                    end else begin
                        fill_cnt_q <= fill_cnt_q - FILL_W'(1);
                    end
                end
                CHECK: begin
                    if (chk_cnt_q == '0) begin
                        if (sat_i || (tries_q == TRY_MAX)) begin
                            state_q     <= OUT;
                            smp_data_q  <= shreg_q[CAND_W-1:0];
                            smp_fail_q  <= ~sat_i;
                            smp_tries_q <= tries_q;
                        end else begin
                            state_q    <= FILL;
                            fill_cnt_q <= FILL_LAST;
                        end
                    end else begin
                        chk_cnt_q <= chk_cnt_q - CHK_W'(1);
                    end
                end
                OUT: begin
                    if (smp_ready_i) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o      = (state_q != IDLE);
    assign smp_valid_o = (state_q == OUT);
    assign cand_o      = shreg_q[CAND_W-1:0];
    assign smp_data_o  = smp_data_q;
    assign smp_fail_o  = smp_fail_q;
    assign smp_tries_o = smp_tries_q;

`ifdef CSP_SAMPLER_STATS_EN
    logic [31:0] stat_tries_q;
    logic [31:0] stat_ok_q;
    logic        try_done;
    logic        ok_handoff;

    assign try_done   = (state_q == FILL) && (fill_cnt_q == '0);
    assign ok_handoff = (state_q == OUT) && smp_ready_i && !smp_fail_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_tries_q <= '0;
            stat_ok_q    <= '0;
        end else if (stat_clr) begin
            stat_tries_q <= '0;
            stat_ok_q    <= '0;
        end else begin
            if (try_done && (stat_tries_q != 32'hFFFF_FFFF)) begin
                stat_tries_q <= stat_tries_q + 32'd1;
            end
            if (ok_handoff && (stat_ok_q != 32'hFFFF_FFFF)) begin
                stat_ok_q <= stat_ok_q + 32'd1;
            end
        end
    end

    assign stat_tries_o = stat_tries_q;
    assign stat_ok_o    = stat_ok_q;
`endif

endmodule
